dense_layer_2_128_to_10_argmax: RTL and testbench
=================================================

Name: dense_layer_2_128_to_10_argmax

Overview:
- Final classifier stage of the CIFAR-10 pipeline. It is the reader/initiator on the Dense_1 output interface.
- Sequence: pulses the upstream start, waits for the upstream done, then reads the 128 ReLU6 activations (4-bit, 0..6) over the upstream read_addr/read_data port.
- Computes 10 signed logits with one MAC per cycle, then reports the argmax class.
- Weights and biases are loaded through a write port, so the block can be tested standalone.

Parameters:
- IN_DIM, 128, input activations read from upstream
- OUT_DIM, 10, number of classes/logits
- ACC_W, 20, signed accumulator/logit width

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle request to run an inference
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when logits/class are valid
- class_idx  out  4  argmax of logits, held until the next done
- logit_addr  in  4  logit read index 0..9
- logit_data  out  20  signed logit[logit_addr], combinational; 0 if addr>9
- up_start  out  1  one-cycle start pulse to upstream dense layer
- up_done  in  1  upstream completion pulse
- up_read_addr  out  7  registered read address to upstream output memory
- up_read_data  in  4  upstream activation, combinational from up_read_addr
- wt_we  in  1  weight/bias write enable
- wt_addr  in  11  0..1279: weight[o*128+i]; 1280..1289: bias[o]; others ignored
- wt_data  in  8  signed weight/bias value

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE; busy=0, done=0, up_start=0, up_read_addr=0, class_idx=0; all logits=0; input buffer=0. Weight/bias memories are NOT reset.
- Reset mid-operation aborts to IDLE with the values above. No done is issued for the aborted run.

State machine:
- IDLE:
  - start=1 -> up_start=1 for exactly one cycle; go to UP_WAIT.
  - wt_we is accepted only in IDLE.
  - up_done in IDLE is ignored.
- UP_WAIT:
  - Hold until up_done=1, then go to LOAD with load counter k=0.
  - No timeout.
- LOAD (129 cycles):
  - In cycle k (0..127), drive up_read_addr=k.
  - In cycle k+1, capture up_read_data into x[k].
  - x is zero-extended to signed 5 bits. Values >6 are stored unchanged (no clamp).
  - After x[127] is captured: go to COMPUTE with o=0, i=0, acc=bias[0] (sign-extended).
- COMPUTE (1280 cycles, one MAC per cycle):
  - Each cycle: acc += x[i]*weight[o*128+i], signed, full ACC_W, no saturation. The worst case |128*6*128+128| = 98432 fits in 20 bits.
  - At i=127: logit[o] = final sum; i resets to 0; o increments; acc reloads bias[o+1].
  - Argmax is updated as each logit completes. The running max is replaced only on strictly greater, so ties resolve to the lowest index.
  - After o=9 completes: class_idx is updated and the FSM goes to DONE.
- DONE:
  - done=1 for one cycle; return to IDLE.
  - done rises in the cycle after the last COMPUTE cycle, i.e. 1409 cycles after the first LOAD cycle.

Other rules:
- start while busy=1 is ignored. wt_we while busy=1 is ignored (memory unchanged).
- start and up_done in the same IDLE cycle: start is accepted, up_done is ignored. The FSM then waits for a new up_done.
- Logits read during COMPUTE are stale or partial. They are valid from the done cycle until the next LOAD ends.
- up_read_addr holds its last value outside LOAD.

Test Plan:
- Full connectivity: all weights=1, biases=0, upstream data all 6 -> every logit=768, class_idx=0 (tie), exactly one done pulse.
- Class selection: as above but weights of neuron 3 = 2 -> logit[3]=1536, others 768, class_idx=3. Then bias[7]=+127, weights of neuron 7 = 2 -> class_idx=7 (1663).
- Negative extreme: all weights=-128, biases=-128, data=6 -> every logit=-98432 (no overflow), class_idx=0.
- Handshake/latency: up_start is a single-cycle pulse one cycle after start. Upstream model returns data[k]=k%7. done is exactly 1409 cycles after the first LOAD cycle. up_read_addr sweeps 0..127 in order.
- Busy protection: start pulsed mid-COMPUTE and wt_we writing weight 0 = 99 mid-LOAD -> no restart, weight unchanged, results match the reference model.
- Reset mid-COMPUTE (cycle 600): busy=0 next cycle, no done, logits=0, class_idx=0. A new start completes correctly using the retained weights.

Source files
------------

// File: rtl/dense_layer_2_128_to_10_argmax.sv
// CIFAR-10 final dense layer: reads 128 activations from Dense_1,
// computes 10 logits with a single MAC and reports the argmax class.
module dense_layer_2_128_to_10_argmax #(
  parameter int IN_DIM  = 128,
  parameter int OUT_DIM = 10,
  parameter int ACC_W   = 20
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       class_idx,
  input  logic [3:0]       logit_addr,
  output logic [ACC_W-1:0] logit_data,
  output logic             up_start,
  input  logic             up_done,
  output logic [6:0]       up_read_addr,
  input  logic [3:0]       up_read_data,
  input  logic             wt_we,
  input  logic [10:0]      wt_addr,
  input  logic [7:0]       wt_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_COMP, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [7:0] k_q, k_d;
  logic [3:0] o_q, o_d;
  logic [6:0] i_q, i_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] max_q, max_d;
  logic [3:0] best_q, best_d;
  logic [3:0] cls_q, cls_d;
  logic up_start_q, up_start_d;
  logic [6:0] addr_q, addr_d;

  logic [3:0] x_q [IN_DIM];
  logic signed [ACC_W-1:0] logit_q [OUT_DIM];
  logic signed [7:0] w_mem [IN_DIM*OUT_DIM];
  logic signed [7:0] b_mem [OUT_DIM];

  logic x_we, logit_we;
  logic [6:0] x_idx;
  logic [3:0] o_nxt;
  logic signed [7:0] w_rd, b_rd, b0_rd;
  logic signed [ACC_W-1:0] x_ext, w_ext, prod, sum;

  assign x_idx = k_q[6:0] - 7'd1;
  assign o_nxt = (o_q == 4'(OUT_DIM-1)) ? 4'd0 : o_q + 4'd1;
  assign w_rd  = w_mem[{o_q, i_q}];
  assign b_rd  = b_mem[o_nxt];
  assign b0_rd = b_mem[0];
  assign x_ext = {{(ACC_W-4){1'b0}}, x_q[i_q]};
  assign w_ext = {{(ACC_W-8){w_rd[7]}}, w_rd};
  assign prod  = x_ext * w_ext;
  assign sum   = acc_q + prod;

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign class_idx    = cls_q;
  assign up_start     = up_start_q;
  assign up_read_addr = addr_q;
  assign logit_data   = (logit_addr < 4'(OUT_DIM))
                      ? logit_q[logit_addr] : '0;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    o_d        = o_q;
    i_d        = i_q;
    acc_d      = acc_q;
    max_d      = max_q;
    best_d     = best_q;
    cls_d      = cls_q;
    up_start_d = 1'b0;
    addr_d     = addr_q;
    x_we       = 1'b0;
    logit_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          up_start_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (up_done) begin
          k_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // address issued in cycle k, its data lands in cycle k+1
        if (k_q < 8'd128) addr_d = k_q[6:0];
        if (k_q != 8'd0) x_we = 1'b1;
        if (k_q == 8'd128) begin
          o_d     = '0;
          i_d     = '0;
          acc_d   = {{(ACC_W-8){b0_rd[7]}}, b0_rd};
          state_d = S_COMP;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      S_COMP: begin
        if (i_q == 7'd127) begin
          logit_we = 1'b1;
          if (o_q == 4'd0 || sum > max_q) begin
            max_d  = sum;
            best_d = o_q;
          end
          if (o_q == 4'(OUT_DIM-1)) begin
            cls_d   = best_d;
            state_d = S_DONE;
          end
          o_d   = o_nxt;
          i_d   = '0;
          acc_d = {{(ACC_W-8){b_rd[7]}}, b_rd};
        end else begin
          acc_d = sum;
          i_d   = i_q + 7'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      o_q        <= '0;
      i_q        <= '0;
      acc_q      <= '0;
      max_q      <= '0;
      best_q     <= '0;
      cls_q      <= '0;
      up_start_q <= 1'b0;
      addr_q     <= '0;
      for (int n = 0; n < IN_DIM; n++) x_q[n] <= '0;
      for (int n = 0; n < OUT_DIM; n++) logit_q[n] <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      o_q        <= o_d;
      i_q        <= i_d;
      acc_q      <= acc_d;
      max_q      <= max_d;
      best_q     <= best_d;
      cls_q      <= cls_d;
      up_start_q <= up_start_d;
      addr_q     <= addr_d;
      if (x_we) x_q[x_idx] <= up_read_data;
      if (logit_we) logit_q[o_q] <= sum;
    end
  end

  // parameter memories survive reset
  always_ff @(posedge clk) begin
    if (wt_we && state_q == S_IDLE) begin
      if (wt_addr < 11'(IN_DIM*OUT_DIM))
        w_mem[wt_addr] <= wt_data;
      else if (wt_addr < 11'(IN_DIM*OUT_DIM + OUT_DIM))
        b_mem[wt_addr[3:0]] <= wt_data;
    end
  end

endmodule

// File: tb/tb_dense_layer_2_128_to_10_argmax.sv
// Randomized self-checking bench for the 128->10 dense + argmax stage,
// with an upstream responder and an integer reference model.
module tb_dense_layer_2_128_to_10_argmax;

  logic        clk = 1'b0;
  logic        resetn, start, up_done, wt_we;
  logic [3:0]  logit_addr;
  logic [10:0] wt_addr;
  logic [7:0]  wt_data;
  logic        busy, done, up_start;
  logic [3:0]  class_idx, up_read_data;
  logic [19:0] logit_data;
  logic [6:0]  up_read_addr;

  int checks = 0;
  int errors = 0;

  int w_m [1280];
  int b_m [10];
  logic [3:0] d_m [128];
  int exp_l [10];
  int exp_c;

  int done_c, ndone, n_ups;
  bit ups1, ups2, addr_ok;
  logic rst_busy, rst_done;

  always #5 clk = ~clk;

  assign up_read_data = d_m[up_read_addr];

  dense_layer_2_128_to_10_argmax dut (
    .clk(clk), .resetn(resetn), .start(start),
    .busy(busy), .done(done), .class_idx(class_idx),
    .logit_addr(logit_addr), .logit_data(logit_data),
    .up_start(up_start), .up_done(up_done),
    .up_read_addr(up_read_addr), .up_read_data(up_read_data),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_wt(input int a, input int v);
    wt_we = 1'b1;
    wt_addr = 11'(a);
    wt_data = 8'(v);
    tick();
    wt_we = 1'b0;
  endtask

  task automatic load_all();
    for (int a = 0; a < 1280; a++) write_wt(a, w_m[a]);
    for (int o = 0; o < 10; o++) write_wt(1280 + o, b_m[o]);
  endtask

  function automatic void model();
    int s;
    for (int o = 0; o < 10; o++) begin
      s = b_m[o];
      for (int i = 0; i < 128; i++)
        s += int'(d_m[i]) * w_m[o*128 + i];
      exp_l[o] = s;
    end
    exp_c = 0;
    for (int o = 1; o < 10; o++)
      if (exp_l[o] > exp_l[exp_c]) exp_c = o;
  endfunction

  task automatic run(input int we_at, input int st_at,
                     input int rst_at, input bit both);
    int c;
    start = 1'b1;
    up_done = both;
    tick();
    start = 1'b0;
    up_done = 1'b0;
    ups1 = up_start;
    tick();
    ups2 = up_start;
    repeat (both ? 10 : $urandom_range(0, 3)) tick();
    up_done = 1'b1;
    tick();
    up_done = 1'b0;
    c = 0; done_c = -1; ndone = 0; n_ups = 0; addr_ok = 1;
    rst_busy = 1'bx; rst_done = 1'bx;
    while (c < 1430) begin
      wt_we = (c == we_at);
      wt_addr = '0;
      wt_data = 8'd99;
      start = (c == st_at);
      resetn = (c != rst_at);
      tick();
      c++;
      wt_we = 1'b0; start = 1'b0; resetn = 1'b1;
      if (c <= 128 && up_read_addr !== 7'(c-1)) addr_ok = 0;
      if (up_start) n_ups++;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        rst_busy = busy;
        rst_done = done;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; up_done = 1'b0; wt_we = 1'b0;
    wt_addr = '0; wt_data = '0; logit_addr = '0;
    repeat (3) tick();
    resetn = 1'b1;
    checks++;
    if ({busy, done, up_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000", {busy, done, up_start});
    end
    checks++;
    if (up_read_addr !== 7'd0 || class_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_addr_cls got %0d/%0d exp 0/0",
               up_read_addr, class_idx);
    end
    for (int o = 0; o < 16; o++) begin
      logit_addr = 4'(o);
      #1;
      checks++;
      if (logit_data !== 20'd0) begin
        errors++;
        $display("FAIL reset_logit%0d got %0d exp 0", o, logit_data);
      end
    end
  endtask

  task automatic test_full_connect();
    for (int a = 0; a < 1280; a++) w_m[a] = 1;
    for (int o = 0; o < 10; o++) b_m[o] = 0;
    for (int i = 0; i < 128; i++) d_m[i] = 4'd6;
    load_all();
    run(-1, -1, -1, 0);
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL full_ndone got %0d exp 1", ndone);
    end
    for (int o = 0; o < 10; o++) begin
      logit_addr = 4'(o);
      #1;
      checks++;
      if (logit_data !== 20'd768) begin
        errors++;
        $display("FAIL full_logit%0d got %0d exp 768", o, logit_data);
      end
    end
    checks++;
    if (class_idx !== 4'd0) begin
      errors++;
      $display("FAIL full_class got %0d exp 0", class_idx);
    end
  endtask

  task automatic test_class_select();
    for (int i = 0; i < 128; i++) begin
      w_m[3*128 + i] = 2;
      write_wt(3*128 + i, 2);
    end
    run(-1, -1, -1, 0);
    for (int o = 0; o < 10; o++) begin
      logit_addr = 4'(o);
      #1;
      checks++;
      if ($signed(logit_data) !== ((o == 3) ? 1536 : 768)) begin
        errors++;
        $display("FAIL sel3_logit%0d got %0d", o, $signed(logit_data));
      end
    end
    checks++;
    if (class_idx !== 4'd3) begin
      errors++;
      $display("FAIL sel3_class got %0d exp 3", class_idx);
    end
    b_m[7] = 127;
    write_wt(1287, 127);
    for (int i = 0; i < 128; i++) begin
      w_m[7*128 + i] = 2;
      write_wt(7*128 + i, 2);
    end
    run(-1, -1, -1, 0);
    logit_addr = 4'd7;
    #1;
    checks++;
    if ($signed(logit_data) !== 1663) begin
      errors++;
      $display("FAIL sel7_logit got %0d exp 1663", $signed(logit_data));
    end
    checks++;
    if (class_idx !== 4'd7) begin
      errors++;
      $display("FAIL sel7_class got %0d exp 7", class_idx);
    end
  endtask

  task automatic test_negative();
    for (int a = 0; a < 1280; a++) w_m[a] = -128;
    for (int o = 0; o < 10; o++) b_m[o] = -128;
    for (int i = 0; i < 128; i++) d_m[i] = 4'd6;
    load_all();
    run(-1, -1, -1, 0);
    for (int o = 0; o < 10; o++) begin
      logit_addr = 4'(o);
      #1;
      checks++;
      if ($signed(logit_data) !== -98432) begin
        errors++;
        $display("FAIL neg_logit%0d got %0d exp -98432",
                 o, $signed(logit_data));
      end
    end
    checks++;
    if (class_idx !== 4'd0) begin
      errors++;
      $display("FAIL neg_class got %0d exp 0", class_idx);
    end
  endtask

  task automatic randomize_params();
    for (int a = 0; a < 1280; a++)
      w_m[a] = int'($urandom_range(0, 255)) - 128;
    for (int o = 0; o < 10; o++)
      b_m[o] = int'($urandom_range(0, 255)) - 128;
    load_all();
  endtask

  task automatic check_results(input string tag);
    model();
    for (int o = 0; o < 10; o++) begin
      logit_addr = 4'(o);
      #1;
      checks++;
      if (logit_data !== 20'(exp_l[o])) begin
        errors++;
        $display("FAIL %s_logit%0d got %0d exp %0d",
                 tag, o, $signed(logit_data), exp_l[o]);
      end
    end
    checks++;
    if (class_idx !== 4'(exp_c)) begin
      errors++;
      $display("FAIL %s_class got %0d exp %0d", tag, class_idx, exp_c);
    end
  endtask

  task automatic test_handshake();
    randomize_params();
    for (int i = 0; i < 128; i++) d_m[i] = 4'(i % 7);
    run(-1, -1, -1, 0);
    checks++;
    if ({ups1, ups2} !== 2'b10 || n_ups !== 0) begin
      errors++;
      $display("FAIL hs_up_start got %b/%0d exp 10/0", {ups1, ups2}, n_ups);
    end
    checks++;
    if (!addr_ok) begin
      errors++;
      $display("FAIL hs_addr_sweep got 0 exp 1");
    end
    checks++;
    if (done_c !== 1409 || ndone !== 1) begin
      errors++;
      $display("FAIL hs_latency got %0d/%0d exp 1409/1", done_c, ndone);
    end
    check_results("hs");
  endtask

  task automatic test_random_data();
    for (int r = 0; r < 2; r++) begin
      randomize_params();
      for (int i = 0; i < 128; i++) d_m[i] = 4'($urandom_range(0, 15));
      run(-1, -1, -1, 0);
      checks++;
      if (done_c !== 1409) begin
        errors++;
        $display("FAIL rnd_latency got %0d exp 1409", done_c);
      end
      check_results("rnd");
    end
  endtask

  task automatic test_busy_protect();
    for (int i = 0; i < 128; i++) d_m[i] = 4'($urandom_range(0, 6));
    d_m[0] = 4'd5;
    w_m[0] = -7;
    write_wt(0, -7);
    run(10, 500, -1, 0);
    checks++;
    if (ndone !== 1 || done_c !== 1409 || n_ups !== 0) begin
      errors++;
      $display("FAIL busy_run got %0d/%0d/%0d exp 1/1409/0",
               ndone, done_c, n_ups);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle got %b exp 0", busy);
    end
    check_results("busy");
  endtask

  task automatic test_start_updone_same();
    for (int i = 0; i < 128; i++) d_m[i] = 4'($urandom_range(0, 6));
    run(-1, -1, -1, 1);
    checks++;
    if (done_c !== 1409 || ndone !== 1) begin
      errors++;
      $display("FAIL same_latency got %0d/%0d exp 1409/1", done_c, ndone);
    end
    check_results("same");
  endtask

  task automatic test_reset_mid();
    run(-1, -1, 729, 0);
    checks++;
    if (rst_busy !== 1'b0 || rst_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl got %b%b exp 00", rst_busy, rst_done);
    end
    checks++;
    if (ndone !== 0 || class_idx !== 4'd0) begin
      errors++;
      $display("FAIL rst_nodone got %0d/%0d exp 0/0", ndone, class_idx);
    end
    for (int o = 0; o < 10; o++) begin
      logit_addr = 4'(o);
      #1;
      checks++;
      if (logit_data !== 20'd0) begin
        errors++;
        $display("FAIL rst_logit%0d got %0d exp 0", o, logit_data);
      end
    end
    run(-1, -1, -1, 0);
    checks++;
    if (done_c !== 1409 || ndone !== 1) begin
      errors++;
      $display("FAIL rst_rerun got %0d/%0d exp 1409/1", done_c, ndone);
    end
    check_results("rerun");
  endtask

  initial begin
    test_reset();
    test_full_connect();
    test_class_select();
    test_negative();
    test_handshake();
    test_random_data();
    test_busy_protect();
    test_start_updone_same();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
